// File: rtl/bram_dual_port_be.sv
// bram_dual_port_be: true dual-port block RAM with byte write enables.
// Both ports share one clock. Port A wins overlapping bytes when both ports
// write the same word. Read-during-write on the same port is selectable
// (old word or merged word). Read data and valid come out 1 + OUT_REG
// cycles after the access edge. A registered pulse flags same-address
// conflicts.
module bram_dual_port_be #(
  parameter int ADDR_WIDTH = 10,
  parameter int DATA_WIDTH = 32,
  parameter int BYTE_WIDTH = 8,
  parameter int RDW_MODE   = 0,
  parameter int OUT_REG    = 0
) (
  input  logic                             clk,
  input  logic                             rst_n,
  input  logic                             en_a,
  input  logic [DATA_WIDTH/BYTE_WIDTH-1:0] we_a,
  input  logic [ADDR_WIDTH-1:0]            addr_a,
  input  logic [DATA_WIDTH-1:0]            din_a,
  output logic [DATA_WIDTH-1:0]            dout_a,
  output logic                             valid_a,
  input  logic                             en_b,
  input  logic [DATA_WIDTH/BYTE_WIDTH-1:0] we_b,
  input  logic [ADDR_WIDTH-1:0]            addr_b,
  input  logic [DATA_WIDTH-1:0]            din_b,
  output logic [DATA_WIDTH-1:0]            dout_b,
  output logic                             valid_b,
  output logic                             collision
);

  localparam int NB    = DATA_WIDTH / BYTE_WIDTH;
  localparam int DEPTH = 1 << ADDR_WIDTH;

  // Storage is deliberately not reset; contents survive rst_n.
  logic [DATA_WIDTH-1:0] mem_r [DEPTH];

  logic [NB-1:0]         wr_a_s;
  logic [NB-1:0]         wr_b_s;
  logic [NB-1:0]         own_b_s;
  logic                  same_addr_s;
  logic [DATA_WIDTH-1:0] old_a_s;
  logic [DATA_WIDTH-1:0] old_b_s;
  logic [DATA_WIDTH-1:0] rdw_a_s;
  logic [DATA_WIDTH-1:0] rdw_b_s;
  logic                  coll_s;

  logic [DATA_WIDTH-1:0] d1_a_r;
  logic [DATA_WIDTH-1:0] d1_b_r;
  logic                  v1_a_r;
  logic                  v1_b_r;
  logic                  coll_r;

  // Replace the bytes of old_word selected by lanes with new_word's bytes.
  function automatic logic [DATA_WIDTH-1:0] byte_merge(
    input logic [DATA_WIDTH-1:0] old_word,
    input logic [DATA_WIDTH-1:0] new_word,
    input logic [NB-1:0]         lanes
  );
    logic [DATA_WIDTH-1:0] res;
    res = old_word;
    for (int i = 0; i < NB; i++) begin
      if (lanes[i]) begin
        res[i*BYTE_WIDTH +: BYTE_WIDTH] = new_word[i*BYTE_WIDTH +: BYTE_WIDTH];
      end else begin
        res[i*BYTE_WIDTH +: BYTE_WIDTH] = old_word[i*BYTE_WIDTH +: BYTE_WIDTH];
      end
    end
    return res;
  endfunction

  // Qualify byte lanes, resolve A-over-B priority and form read-during-write data.
  always_comb begin
    same_addr_s = (addr_a == addr_b);
    if (en_a) begin
      wr_a_s = we_a;
    end else begin
      wr_a_s = {NB{1'b0}};
    end
    if (en_b) begin
      own_b_s = we_b;
    end else begin
      own_b_s = {NB{1'b0}};
    end
    // B loses any lane that A is writing in the same word.
    if (en_b && same_addr_s) begin
      wr_b_s = own_b_s & ~wr_a_s;
    end else begin
      wr_b_s = own_b_s;
    end
    old_a_s = mem_r[addr_a];
    old_b_s = mem_r[addr_b];
    if (RDW_MODE == 32'sd1) begin
      rdw_a_s = byte_merge(old_a_s, din_a, wr_a_s);
      rdw_b_s = byte_merge(old_b_s, din_b, own_b_s);
    end else begin
      rdw_a_s = old_a_s;
      rdw_b_s = old_b_s;
    end
    coll_s = en_a & en_b & same_addr_s & ((|we_a) | (|we_b));
  end

  // Byte-lane writes from both ports; nothing is written while in reset.
  always_ff @(posedge clk) begin
    if (rst_n) begin
      for (int i = 0; i < NB; i++) begin
        if (wr_a_s[i]) begin
          mem_r[addr_a][i*BYTE_WIDTH +: BYTE_WIDTH] <= din_a[i*BYTE_WIDTH +: BYTE_WIDTH];
        end
        if (wr_b_s[i]) begin
          mem_r[addr_b][i*BYTE_WIDTH +: BYTE_WIDTH] <= din_b[i*BYTE_WIDTH +: BYTE_WIDTH];
        end
      end
    end
  end

  // First read stage: capture read data on enabled cycles, track valid and collision.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      d1_a_r <= {DATA_WIDTH{1'b0}};
      d1_b_r <= {DATA_WIDTH{1'b0}};
      v1_a_r <= 1'b0;
      v1_b_r <= 1'b0;
      coll_r <= 1'b0;
    end else begin
      v1_a_r <= en_a;
      v1_b_r <= en_b;
      coll_r <= coll_s;
      if (en_a) begin
        d1_a_r <= rdw_a_s;
      end
      if (en_b) begin
        d1_b_r <= rdw_b_s;
      end
    end
  end

  assign collision = coll_r;

  if (OUT_REG == 32'sd1) begin : g_out_reg
    logic [DATA_WIDTH-1:0] d2_a_r;
    logic [DATA_WIDTH-1:0] d2_b_r;
    logic                  v2_a_r;
    logic                  v2_b_r;

    // Optional output stage: forward stage-one data only when it is valid.
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        d2_a_r <= {DATA_WIDTH{1'b0}};
        d2_b_r <= {DATA_WIDTH{1'b0}};
        v2_a_r <= 1'b0;
        v2_b_r <= 1'b0;
      end else begin
        v2_a_r <= v1_a_r;
        v2_b_r <= v1_b_r;
        if (v1_a_r) begin
          d2_a_r <= d1_a_r;
        end
        if (v1_b_r) begin
          d2_b_r <= d1_b_r;
        end
      end
    end

    assign dout_a  = d2_a_r;
    assign dout_b  = d2_b_r;
    assign valid_a = v2_a_r;
    assign valid_b = v2_b_r;
  end else begin : g_no_out_reg
    assign dout_a  = d1_a_r;
    assign dout_b  = d1_b_r;
    assign valid_a = v1_a_r;
    assign valid_b = v1_b_r;
  end

endmodule

// File: tb/tb_bram_dual_port_be.sv
// Testbench for bram_dual_port_be: two instances share the same stimulus
// (READ_FIRST with output register, WRITE_FIRST without). A reference
// memory predicts each read at issue time into per-stream queues, which
// are popped when the DUT raises valid.
module tb_bram_dual_port_be;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        en_a, en_b;
  logic [3:0]  we_a, we_b;
  logic [9:0]  addr_a, addr_b;
  logic [31:0] din_a, din_b;

  logic [31:0] dout_a0, dout_b0, dout_a1, dout_b1;
  logic        valid_a0, valid_b0, valid_a1, valid_b1;
  logic        coll0, coll1;

  always #5 clk = ~clk;

  bram_dual_port_be #(.ADDR_WIDTH(10), .DATA_WIDTH(32), .BYTE_WIDTH(8),
                      .RDW_MODE(0), .OUT_REG(1)) dut_rf (
    .clk(clk), .rst_n(rst_n),
    .en_a(en_a), .we_a(we_a), .addr_a(addr_a), .din_a(din_a),
    .dout_a(dout_a0), .valid_a(valid_a0),
    .en_b(en_b), .we_b(we_b), .addr_b(addr_b), .din_b(din_b),
    .dout_b(dout_b0), .valid_b(valid_b0),
    .collision(coll0)
  );

  bram_dual_port_be #(.ADDR_WIDTH(10), .DATA_WIDTH(32), .BYTE_WIDTH(8),
                      .RDW_MODE(1), .OUT_REG(0)) dut_wf (
    .clk(clk), .rst_n(rst_n),
    .en_a(en_a), .we_a(we_a), .addr_a(addr_a), .din_a(din_a),
    .dout_a(dout_a1), .valid_a(valid_a1),
    .en_b(en_b), .we_b(we_b), .addr_b(addr_b), .din_b(din_b),
    .dout_b(dout_b1), .valid_b(valid_b1),
    .collision(coll1)
  );

  // Streams: 0 = rf port A, 1 = rf port B, 2 = wf port A, 3 = wf port B.
  logic [31:0] dout_s [4];
  logic        valid_s [4];
  assign dout_s[0] = dout_a0;
  assign dout_s[1] = dout_b0;
  assign dout_s[2] = dout_a1;
  assign dout_s[3] = dout_b1;
  assign valid_s[0] = valid_a0;
  assign valid_s[1] = valid_b0;
  assign valid_s[2] = valid_a1;
  assign valid_s[3] = valid_b1;

  typedef struct packed {
    logic        known;
    logic [31:0] data;
    logic [31:0] due;
  } exp_t;

  exp_t        sb [4][$];
  exp_t        mon_e;
  logic [31:0] last_dout [4];
  logic [31:0] mem_m [1024];
  logic [31:0] edge_n = 32'd0;
  logic        mon_on;
  int          n_checks = 0;
  int          n_errors = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] merge(input logic [31:0] old_w, input logic [31:0] new_w,
                                        input logic [3:0] we);
    logic [31:0] r;
    r = old_w;
    for (int i = 0; i < 4; i++) begin
      if (we[i]) r[i*8 +: 8] = new_w[i*8 +: 8];
    end
    return r;
  endfunction

  function automatic exp_t mk(input logic [31:0] d, input logic [31:0] due);
    exp_t e;
    e.known = ((^d) !== 1'bx);
    e.data  = d;
    e.due   = due;
    return e;
  endfunction

  always @(posedge clk) edge_n <= edge_n + 32'd1;

  // Drive one cycle of stimulus, predict reads/writes, check collision after the edge.
  task automatic cyc(input logic ea, input logic [3:0] wa, input logic [9:0] aa, input logic [31:0] da,
                     input logic eb, input logic [3:0] wb, input logic [9:0] ab, input logic [31:0] db);
    logic [31:0] oa, ob;
    logic        ce;
    en_a = ea; we_a = wa; addr_a = aa; din_a = da;
    en_b = eb; we_b = wb; addr_b = ab; din_b = db;
    ce = 1'b0;
    if (rst_n) begin
      oa = mem_m[aa];
      ob = mem_m[ab];
      if (ea) begin
        sb[0].push_back(mk(oa, edge_n + 32'd2));
        sb[2].push_back(mk(merge(oa, da, wa), edge_n + 32'd1));
      end
      if (eb) begin
        sb[1].push_back(mk(ob, edge_n + 32'd2));
        sb[3].push_back(mk(merge(ob, db, wb), edge_n + 32'd1));
      end
      ce = ea && eb && (aa == ab) && ((|wa) || (|wb));
      if (eb) mem_m[ab] = merge(mem_m[ab], db, wb);
      if (ea) mem_m[aa] = merge(mem_m[aa], da, wa);
    end
    @(posedge clk);
    #1;
    chk("collision_rf", 32'(coll0), 32'(ce));
    chk("collision_wf", 32'(coll1), 32'(ce));
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, "_dout_a_rf"}, dout_a0, 32'd0);
    chk({tag, "_dout_b_rf"}, dout_b0, 32'd0);
    chk({tag, "_dout_a_wf"}, dout_a1, 32'd0);
    chk({tag, "_dout_b_wf"}, dout_b1, 32'd0);
    chk({tag, "_valid_rf"}, 32'({valid_a0, valid_b0}), 32'd0);
    chk({tag, "_valid_wf"}, 32'({valid_a1, valid_b1}), 32'd0);
    chk({tag, "_coll"}, 32'({coll0, coll1}), 32'd0);
  endtask

  task automatic idle();
    cyc(1'b0, 4'h0, 10'd0, 32'd0, 1'b0, 4'h0, 10'd0, 32'd0);
  endtask

  // Scoreboard: pop on valid, check data and latency; check hold when not valid.
  always @(negedge clk) begin
    if (mon_on) begin
      for (int s = 0; s < 4; s++) begin
        if (valid_s[s]) begin
          if (sb[s].size() == 0) begin
            chk($sformatf("spurious_valid_s%0d", s), 32'(valid_s[s]), 32'd0);
          end else begin
            mon_e = sb[s].pop_front();
            if (mon_e.known) chk($sformatf("rdata_s%0d", s), dout_s[s], mon_e.data);
            chk($sformatf("rlat_s%0d", s), edge_n, mon_e.due);
          end
          last_dout[s] = dout_s[s];
        end else begin
          chk($sformatf("hold_s%0d", s), dout_s[s], last_dout[s]);
        end
      end
    end
  end

  initial begin
    mon_on = 1'b0;
    rst_n  = 1'b1;
    en_a = 1'b0; we_a = 4'h0; addr_a = 10'd0; din_a = 32'd0;
    en_b = 1'b0; we_b = 4'h0; addr_b = 10'd0; din_b = 32'd0;
    for (int s = 0; s < 4; s++) last_dout[s] = 32'd0;
    #2 rst_n = 1'b0;
    #1 chk_zero("reset");
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    mon_on = 1'b1;

    // Preload the words used below.
    cyc(1'b1, 4'hF, 10'd0, 32'h0A0A0A0A, 1'b1, 4'hF, 10'd1, 32'h1B1B1B1B);
    cyc(1'b1, 4'hF, 10'd2, 32'h2C2C2C2C, 1'b1, 4'hF, 10'd3, 32'h00000022);
    cyc(1'b1, 4'hF, 10'd7, 32'h00000009, 1'b1, 4'hF, 10'd9, 32'h00000000);
    cyc(1'b1, 4'hF, 10'd1023, 32'hFEEDF00D, 1'b0, 4'h0, 10'd0, 32'd0);
    for (int i = 10; i < 16; i++) cyc(1'b1, 4'hF, 10'(i), $urandom, 1'b0, 4'h0, 10'd0, 32'd0);

    // Byte-write merge, then read back.
    cyc(1'b1, 4'hF, 10'd5, 32'hAABBCCDD, 1'b0, 4'h0, 10'd0, 32'd0);
    cyc(1'b1, 4'h5, 10'd5, 32'h11223344, 1'b0, 4'h0, 10'd0, 32'd0);
    cyc(1'b1, 4'h0, 10'd5, 32'd0, 1'b0, 4'h0, 10'd0, 32'd0);

    // Same-port read-during-write, then plain read.
    cyc(1'b1, 4'hF, 10'd9, 32'hDEADBEEF, 1'b0, 4'h0, 10'd0, 32'd0);
    cyc(1'b1, 4'h0, 10'd9, 32'd0, 1'b0, 4'h0, 10'd0, 32'd0);

    // Dual-write collision on addr 3, then read on B.
    cyc(1'b1, 4'hC, 10'd3, 32'h11111111, 1'b1, 4'h6, 10'd3, 32'h22222222);
    cyc(1'b0, 4'h0, 10'd0, 32'd0, 1'b1, 4'h0, 10'd3, 32'd0);

    // Cross-port read of addr 7 while A writes it.
    cyc(1'b1, 4'hF, 10'd7, 32'h00000005, 1'b1, 4'h0, 10'd7, 32'd0);
    cyc(1'b0, 4'h0, 10'd0, 32'd0, 1'b1, 4'h0, 10'd7, 32'd0);

    // Back-to-back reads, then reads with gaps; max address included.
    for (int i = 0; i < 4; i++) cyc(1'b1, 4'h0, 10'(i), 32'd0, 1'b0, 4'h0, 10'd0, 32'd0);
    for (int i = 0; i < 6; i++) cyc(1'((i % 3) != 1), 4'h0, 10'(i % 4), 32'd0,
                                    1'b1, 4'h0, 10'd1023, 32'd0);
    repeat (3) idle();

    // Reset while reads are in flight; writes during reset must be dropped.
    cyc(1'b1, 4'h0, 10'd5, 32'd0, 1'b1, 4'h0, 10'd5, 32'd0);
    #1 rst_n = 1'b0;
    for (int s = 0; s < 4; s++) begin
      sb[s].delete();
      last_dout[s] = 32'd0;
    end
    #1 chk_zero("midreset");
    cyc(1'b1, 4'hF, 10'd5, 32'hBAD0BAD0, 1'b1, 4'hF, 10'd5, 32'h0BAD0BAD);
    cyc(1'b1, 4'hF, 10'd5, 32'hBAD0BAD0, 1'b1, 4'hF, 10'd5, 32'h0BAD0BAD);
    rst_n = 1'b1;
    idle();
    cyc(1'b1, 4'h0, 10'd5, 32'd0, 1'b1, 4'h0, 10'd5, 32'd0);

    // Random traffic on a small address set including the top word.
    for (int k = 0; k < 80; k++) begin
      int unsigned ra, rb;
      ra = $urandom_range(0, 6);
      rb = $urandom_range(0, 6);
      cyc(1'($urandom_range(0, 1)), 4'($urandom_range(0, 15)),
          (ra == 6) ? 10'd1023 : 10'(10 + ra), $urandom,
          1'($urandom_range(0, 1)), 4'($urandom_range(0, 15)),
          (rb == 6) ? 10'd1023 : 10'(10 + rb), $urandom);
    end
    repeat (4) idle();

    for (int s = 0; s < 4; s++) chk($sformatf("drain_s%0d", s), 32'(sb[s].size()), 32'd0);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
